// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator driven by a valid/ready command stream.
// Define APB_MASTER_TIMEOUT_EN to build the ACCESS wait-state timeout.
module apb_master #(
  parameter logic [31:0] START_ADDRESS   = 32'h8c000000,
  parameter logic [31:0] END_ADDRESS     = 32'h8c0004FC,
  parameter int          MAX_WAIT_STATES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        addr_ok;
  logic        bus_load;
  logic        rsp_load;
  logic        rsp_err_nxt;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_nxt;
  logic [31:0] rsp_rdata_q;

  assign addr_ok = (cmd_addr >= START_ADDRESS) && (cmd_addr <= END_ADDRESS) &&
                   (cmd_addr[1:0] == 2'b00);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (MAX_WAIT_STATES > 0) ? $clog2(MAX_WAIT_STATES + 1) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             timeout_set;
  logic             rsp_to_q;

  // Counter holds the number of ACCESS cycles already spent with PREADY low; it saturates.
  assign timeout_hit = (wait_cnt == CNT_W'(MAX_WAIT_STATES));

  always_ff @(posedge clk) begin
    if (!rst_n || state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!PREADY && !timeout_hit) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_to_q <= 1'b0;
    end else if (rsp_load) begin
      rsp_to_q <= timeout_set;
    end
  end

  assign rsp_timeout = rsp_valid & rsp_to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus_load      = 1'b0;
    rsp_load      = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = '0;
`ifdef APB_MASTER_TIMEOUT_EN
    timeout_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (addr_ok) begin
            bus_load  = 1'b1;
            state_nxt = SETUP;
          end else begin
            // Out-of-window or misaligned: answer locally, the bus never sees it.
            rsp_load    = 1'b1;
            rsp_err_nxt = 1'b1;
            state_nxt   = RESP;
          end
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_load      = 1'b1;
          rsp_err_nxt   = PSLVERR;
          rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
          state_nxt     = RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (timeout_hit) begin
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
          timeout_set = 1'b1;
          state_nxt   = RESP;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus address/data are only reloaded by a decoded command, so they hold between transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else if (bus_load) begin
      PADDR  <= cmd_addr;
      PWRITE <= cmd_write;
      PWDATA <= cmd_write ? cmd_wdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (rsp_load) begin
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_err_q   <= rsp_err_nxt;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? rsp_rdata_q : '0;
  assign rsp_err   = rsp_valid & rsp_err_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB initiator that turns a valid/ready command stream into APB read/write transfers and returns one response per command.
- Drives the DUT-side APB slave, for example the audioport register bank. Used as the bus master in integration and system-level benches.
- Commands outside the decoded DUT window, or with a misaligned address, are rejected locally and never reach the bus.
- A wait-state limit keeps a stalled slave from hanging the master.

Parameters:
START_ADDRESS, 32'h8c000000, lowest decoded byte address (inclusive)
END_ADDRESS, 32'h8c0004FC, highest decoded word address (inclusive)
MAX_WAIT_STATES, 32, maximum accepted ACCESS cycles with PREADY low before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  32  byte address
cmd_wdata  in  32  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
rsp_rdata  out  32  read data (0 for writes and errors)
rsp_err  out  1  decode error, PSLVERR or timeout
rsp_timeout  out  1  error caused by wait-state timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  32  APB address
PWDATA  out  32  APB write data
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset: the clk edge with rst_n=0 forces IDLE. All outputs go to 0 except cmd_ready=1. The wait counter clears. This applies from any state, including mid-ACCESS: PSEL/PENABLE drop at that edge, the aborted transfer gets no response, and any pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP. cmd_ready=1 only in IDLE, so the block holds one command at a time.
- IDLE, on cmd_valid: latch cmd_write/cmd_addr/cmd_wdata.
  - If START_ADDRESS<=addr<=END_ADDRESS and addr[1:0]==0, go to SETUP.
  - Otherwise go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. PSEL is never asserted.
- SETUP: exactly one cycle. PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latch; PWDATA=0 for reads. Always goes to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable until the transfer completes.
  - PREADY=1: complete. For reads, rsp_rdata=PRDATA; for writes, rsp_rdata=0. rsp_err=PSLVERR. Go to RESP.
  - PREADY=0: wait counter increments.
  - Timeout: if PREADY is still 0 on ACCESS cycle MAX_WAIT_STATES+1 (the counter equals MAX_WAIT_STATES), abort. Go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A PREADY=1 on that same cycle completes normally. The completion check takes priority over the timeout check.
- Leaving ACCESS: PSEL=0 and PENABLE=0 on the next cycle. There are no back-to-back bus transfers without an IDLE cycle.
- RESP: rsp_valid=1 and all rsp_* fields are held stable until rsp_ready=1, then go to IDLE.
  - A command presented during RESP is not accepted.
  - rsp_* outputs are don't-care outside RESP and are driven 0.
- APB outputs in IDLE/RESP: PSEL=0, PENABLE=0. PADDR/PWRITE/PWDATA keep their last values.
- Latency, zero wait states: command accepted at edge T, SETUP in cycle T+1, ACCESS in T+2, rsp_valid in T+3. Each wait state adds one cycle.
- Wait counter width: $clog2(MAX_WAIT_STATES+1) bits. It saturates and never wraps.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined: wait-state timeout active as described above.
- Undefined: no counter is built. ACCESS waits indefinitely for PREADY, and rsp_timeout is tied to 0.

Test Plan:
1. Write addr 0x8c000010, data 0xDEADBEEF, PREADY=1 -> one SETUP cycle (PSEL=1, PENABLE=0, PWRITE=1, PADDR=0x8c000010), one ACCESS cycle, rsp_valid 3 cycles after acceptance, rsp_err=0.
2. Read 0x8c0004FC, slave inserts 3 wait states, PRDATA=0x12345678 -> ACCESS lasts 4 cycles with PADDR stable, rsp_rdata=0x12345678, rsp_err=0.
3. Commands to 0x8c000500 and to 0x8c000002 -> PSEL never rises, rsp_valid the cycle after acceptance, rsp_err=1, rsp_timeout=0.
4. PREADY held 0 -> exactly 33 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1. Repeat with PREADY=1 on ACCESS cycle 33 -> normal completion, rsp_timeout=0.
5. Read with PSLVERR=1 and PREADY=1, rsp_ready held 0 for 5 cycles -> rsp_err=1, rsp_timeout=0, response stable across all 5 cycles, cmd_ready=0 throughout.
6. rst_n=0 for one cycle during ACCESS -> at that edge PSEL=0, PENABLE=0, rsp_valid=0 and cmd_ready=1; no response ever emitted for the aborted command.
